// File: rtl/outbox.sv
// rtl/outbox.sv - output FIFO draining CPU OUTBOX words to a valid/ready consumer
//
// Purpose: buffers words pushed by the control unit and presents them in order
// on a valid/ready stream. Reports registered full/empty, occupancy, and a
// sticky overflow flag when the CPU writes into a full queue.
//
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   wO, DIN        write strobe and word from the control unit
//   full, empty    registered status, consistent with count
//   o_valid,
//   o_data,
//   o_ready        head-of-queue stream towards the consumer
//   count          occupancy 0..DEPTH
//   overflow       sticky, set by a write attempt while full
module outbox #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wO,
   input  logic [DATA_WIDTH-1:0] DIN,
   output logic                  full,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  o_ready,
   output logic                  empty,
   output logic [AW:0]           count,
   output logic                  overflow
);

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wp_q, wp_d;
   logic [AW-1:0]         rp_q, rp_d;
   logic [AW:0]           cnt_q, cnt_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  overflow_q, overflow_d;
   logic                  push, pop;

   always_comb begin
      push       = wO & ~full_q;
      // A pop in the same cycle does not free a slot for a write while full.
      pop        = ~empty_q & o_ready;
      wp_d       = wp_q;
      rp_d       = rp_q;
      cnt_d      = cnt_q;
      overflow_d = overflow_q | (wO & full_q);

      if (push) begin
         wp_d = wp_q + PTR_ONE;
      end
      if (pop) begin
         rp_d = rp_q + PTR_ONE;
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      // Status flags come from the next count so they line up with count.
      full_d  = (cnt_d == CNT_FULL);
      empty_d = (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q       <= '0;
         rp_q       <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; buffered words are discarded via the pointers.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wp_q] <= DIN;
      end
   end

   assign o_data   = mem_q[rp_q];
   assign o_valid  = ~empty_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign count    = cnt_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_outbox.sv
// tb/tb_outbox.sv - directed self-checking bench for outbox (DEPTH=4)
module tb_outbox;

   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          wO;
   logic [DW-1:0] DIN;
   logic          full;
   logic          o_valid;
   logic [DW-1:0] o_data;
   logic          o_ready;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;

   int errors = 0;
   int checks = 0;

   outbox #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .wO       (wO),
      .DIN      (DIN),
      .full     (full),
      .o_valid  (o_valid),
      .o_data   (o_data),
      .o_ready  (o_ready),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      wO = 1'b1;
      DIN = d;
      step();
      wO = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; wO = 1'b0; DIN = '0; o_ready = 1'b0;
      #2;
      do_reset();

      // Reset then idle
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_valid", o_valid, 0);
      check("rst_ovf", overflow, 0);
      o_ready = 1'b1;
      repeat (3) step();
      o_ready = 1'b0;
      check("idle_ready_count", count, 0);
      check("idle_ready_empty", empty, 1);

      // Ordered drain
      push(8'h05); push(8'h0A); push(8'hFF);
      check("drain_count3", count, 3);
      o_ready = 1'b1;
      check("drain_d0", o_data, 8'h05); step();
      check("drain_d1", o_data, 8'h0A); step();
      check("drain_d2", o_data, 8'hFF); check("drain_v2", o_valid, 1); step();
      o_ready = 1'b0;
      check("drain_empty", empty, 1);
      check("drain_count0", count, 0);

      // Full and overflow
      for (int i = 1; i <= 4; i++) push(DW'(i));
      check("full_flag", full, 1);
      check("full_count", count, 4);
      check("full_noovf", overflow, 0);
      push(8'h99);
      check("ovf_set", overflow, 1);
      check("ovf_count", count, 4);
      o_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovf_drain%0d", i), o_data, i);
         step();
      end
      o_ready = 1'b0;
      check("ovf_drain_empty", empty, 1);
      check("ovf_sticky", overflow, 1);

      // Push while full with simultaneous pop
      for (int i = 0; i < 4; i++) push(DW'(8'hA0 + i));
      check("fp_full", full, 1);
      wO = 1'b1; DIN = 8'h77; o_ready = 1'b1;
      step();
      wO = 1'b0; o_ready = 1'b0;
      check("fp_count", count, 3);
      check("fp_full_after", full, 0);
      check("fp_ovf", overflow, 1);
      check("fp_head", o_data, 8'hA1);
      // Free slot now accepted in the next cycle
      push(8'h55);
      check("fp_refill_full", full, 1);
      o_ready = 1'b1;
      check("fp_d1", o_data, 8'hA1); step();
      check("fp_d2", o_data, 8'hA2); step();
      check("fp_d3", o_data, 8'hA3); step();
      check("fp_d4", o_data, 8'h55); step();
      o_ready = 1'b0;
      check("fp_empty", empty, 1);
      do_reset();
      check("ovf_clear_rst", overflow, 0);

      // Push into empty with o_ready high: not popped that cycle
      o_ready = 1'b1;
      push(8'h3C);
      check("pe_valid", o_valid, 1);
      check("pe_data", o_data, 8'h3C);
      check("pe_count", count, 1);
      step();
      o_ready = 1'b0;
      check("pe_popped", empty, 1);

      // Sustained streaming at count=2 with pointer wrap
      push(8'h10); push(8'h11);
      check("st_count_pre", count, 2);
      wO = 1'b1; o_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         DIN = DW'(8'h12 + i);
         check($sformatf("st_out%0d", i), o_data, 8'h10 + i);
         check($sformatf("st_cnt%0d", i), count, 2);
         step();
      end
      wO = 1'b0;
      check("st_tail0", o_data, 8'h1A); step();
      check("st_tail1", o_data, 8'h1B); step();
      o_ready = 1'b0;
      check("st_empty", empty, 1);

      // Reset mid-operation
      push(8'hC1); push(8'hC2); push(8'hC3);
      check("mr_count3", count, 3);
      rst = 1'b1; wO = 1'b1; DIN = 8'h42;
      step();
      rst = 1'b0; wO = 1'b0;
      check("mr_count0", count, 0);
      check("mr_empty", empty, 1);
      push(8'h42);
      check("mr_valid", o_valid, 1);
      check("mr_first", o_data, 8'h42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/outbox.md
# outbox

Output FIFO for the HRM CPU: the write-side counterpart of the inbox. The control unit pushes the accumulator value on an OUTBOX instruction; a downstream consumer (test harness, UART bridge or display) drains words through a valid/ready stream. The block buffers words in order, reports full, empty and occupancy, and latches a sticky overflow flag when the CPU writes into a full queue.

## Interface
- DATA_WIDTH, 8, word width, matching the CPU data path
- DEPTH, 32, number of entries; must be a power of 2, at least 2
- AW, log2(DEPTH), derived pointer width; not overridable
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high; one clock; reset is synchronous and active-high
- wO  in  1  write strobe from the control unit; one push per cycle while high
- DIN  in  DATA_WIDTH  word to push; sampled when wO=1
- full  out  1  registered; 1 when count==DEPTH
- o_valid  out  1  head word available (count!=0)
- o_data  out  DATA_WIDTH  head word; meaningful only while o_valid=1
- o_ready  in  1  consumer accepts head word this cycle
- empty  out  1  registered; 1 when count==0 (o_valid = ~empty)
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set by a write attempt while full

## Operation
- Storage: DEPTH x DATA_WIDTH array, write pointer wp and read pointer rp (AW bits each), occupancy counter cnt (AW+1 bits).
- push = wO & ~full; pop = o_valid & o_ready.
- On push: mem[wp] <= DIN; wp <= wp+1, wrapping modulo DEPTH with no special case.
- On pop: rp <= rp+1, wrapping modulo DEPTH.
- cnt: +1 on push only, -1 on pop only, unchanged on both or neither.
- full and empty are registered and derived from the next value of cnt, so they are valid in the same cycle as count.
- wO while full: the write is dropped, no state other than overflow changes, and overflow <= 1. This holds even if a pop happens in the same cycle; the CPU must not rely on a same-cycle free slot.
- o_ready while empty: no effect; o_data is don't-care.
- overflow clears only on rst.
- rst: wp=rp=0, cnt=0, empty=1, full=0, o_valid=0, overflow=0; memory contents are not cleared. Reset takes priority over a simultaneous wO or o_ready and discards all buffered words.

## Timing
- o_data = mem[rp] is an asynchronous read of the head word; no read latency.
- Write-to-visible latency is 1 cycle: a push at edge N makes o_valid=1 and o_data=DIN after edge N.
- Throughput is 1 push plus 1 pop per cycle sustained when 0<count<DEPTH.
- Push and pop in the same cycle leave count, full and empty unchanged; both pointers advance.
- Push into empty with o_ready=1 in the same cycle: the word is not popped that cycle (o_valid was 0) and appears after the edge.
- Pop from full without a write makes full=0 after the edge; a wO in the next cycle is accepted.
- Consumer handshake: o_data and o_valid hold stable until pop; o_valid never drops without a pop or rst.

## Test plan
- Reset then idle: after rst=1 for 1 cycle, empty=1, full=0, count=0, o_valid=0, overflow=0; o_ready=1 for 3 cycles leaves count at 0.
- Ordered drain (DEPTH=4): push 0x05, 0x0A, 0xFF with o_ready=0 gives count=3; then o_ready=1 yields o_data 0x05, 0x0A, 0xFF on 3 consecutive cycles, followed by empty=1.
- Full and overflow (DEPTH=4): push 0x01..0x04 gives full=1 and count=4; a push of 0x99 is dropped and overflow=1; the drain returns 0x01..0x04 only; overflow stays 1 until rst.
- Simultaneous push and pop at count=2: count stays 2; after 10 cycles of sustained streaming of an incrementing pattern 0x10.. with pointer wrap, the output sequence is exact with no gaps.
- Push while full with simultaneous pop (DEPTH=4, full): the pop is accepted, the write is dropped, count=3, overflow=1.
- Reset mid-operation: with 3 words queued, rst=1 together with wO=1 and DIN=0x42 gives count=0 and empty=1 afterward; a following push of 0x42 reads back as the first word out.
